processador_multiciclo: RTL and testbench

Parametrised multicycle successor of the single-cycle `Processador` top: one control FSM sequences fetch, decode, execute, memory and write-back over a single shared memory port with a request/acknowledge handshake. It supports a configurable data width and reset vector, contains its own register file, and retires ADD, SUB, ADDI, load-doubleword/word, store-doubleword/word and BEQ. Illegal opcodes halt the core in an error state. It sits between the system memory model and the testbench, replacing the `UC` + `DataFlow` pair.

---
 rtl/processador_multiciclo_if.sv | 24 ++
 rtl/processador_multiciclo.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_processador_multiciclo.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/processador_multiciclo_if.sv
// Shared memory port of the multicycle core. A single request/acknowledge
// channel carries both instruction fetches and data loads/stores.
interface processador_multiciclo_if #(
  parameter int XLEN = 64
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  // Core side: issues requests and waits for the acknowledge.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Memory side: answers requests, possibly after wait cycles.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/processador_multiciclo.sv
// Multicycle RV-subset core: one control FSM walks every instruction through
// fetch, decode, execute, memory and write-back over one shared memory port.
// Retires ADD, SUB, ADDI, LD/LW, SD/SW and BEQ; anything else parks the core
// in ERRO until reset.
module processador_multiciclo #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  processador_multiciclo_if.master mem,
  output logic [XLEN-1:0]          doutPC,
  output logic                     WeM,
  output logic                     halted,
  output logic [31:0]              n_instr
);

  typedef enum logic [2:0] {
    BUSCA,
    DECODIFICA,
    EXECUTA,
    MEMORIA,
    ESCRITA,
    ERRO
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_ADDI,
    OP_LOAD,
    OP_STORE,
    OP_BEQ
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Memory accesses are always the native width: doubleword on RV64, word on RV32.
  localparam logic [2:0] F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,   state_d;
  op_e             op_q,      op_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [31:0]     instr_q,   instr_d;
  logic [XLEN-1:0] a_q,       a_d;
  logic [XLEN-1:0] b_q,       b_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [XLEN-1:0] alu_q,     alu_d;
  logic [XLEN-1:0] mdr_q,     mdr_d;
  logic [31:0]     n_instr_q, n_instr_d;
  logic [XLEN-1:0] regs_q [32];

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                  instr_q[30:25], instr_q[11:8], 1'b0};

  // ---------------------------------------------------------------------------
  // Decode: classify the latched instruction and pick its immediate format
  // ---------------------------------------------------------------------------
  logic            dec_legal;
  op_e             dec_op;
  logic [XLEN-1:0] dec_imm;

  // Decode the latched instruction into an operation and its immediate.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_imm   = imm_i;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = OP_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_ADDI;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_MEM) begin
          dec_legal = 1'b1;
          dec_op    = OP_LOAD;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_MEM) begin
          dec_legal = 1'b1;
          dec_op    = OP_STORE;
          dec_imm   = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_BEQ;
          dec_imm   = imm_b;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU and branch target (all arithmetic wraps modulo 2^XLEN)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;

  // Select the ALU operation from the decoded instruction class.
  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      default: alu_res = a_q + imm_q;
    endcase
  end

  assign pc_plus4  = pc_q + XLEN'(4);
  assign br_target = pc_q + imm_q;

  // ---------------------------------------------------------------------------
  // Control FSM: next state, datapath updates and memory request decode
  // ---------------------------------------------------------------------------
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;
  logic            retire;

  // Sequence one instruction through the phases and decide every register update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = pc_q;
    rf_we     = 1'b0;
    rf_wdata  = (op_q == OP_LOAD) ? mdr_q : alu_q;
    retire    = 1'b0;

    case (state_q)
      BUSCA: begin
        bus_req = 1'b1;
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata[31:0];
          state_d = DECODIFICA;
        end
      end

      DECODIFICA: begin
        a_d     = regs_q[rs1];
        b_d     = regs_q[rs2];
        imm_d   = dec_imm;
        op_d    = dec_op;
        state_d = dec_legal ? EXECUTA : ERRO;
      end

      EXECUTA: begin
        alu_d = alu_res;
        case (op_q)
          OP_LOAD, OP_STORE: state_d = MEMORIA;
          OP_BEQ: begin
            if (a_q == b_q) begin
              // A misaligned taken branch halts with the PC still on the branch.
              if (br_target[1:0] != 2'b00) begin
                state_d = ERRO;
              end else begin
                pc_d    = br_target;
                retire  = 1'b1;
                state_d = BUSCA;
              end
            end else begin
              pc_d    = pc_plus4;
              retire  = 1'b1;
              state_d = BUSCA;
            end
          end
          default: state_d = ESCRITA;
        endcase
      end

      MEMORIA: begin
        bus_req  = 1'b1;
        bus_we   = (op_q == OP_STORE);
        bus_addr = alu_q;
        if (mem.mem_ack) begin
          if (op_q == OP_STORE) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = BUSCA;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = ESCRITA;
          end
        end
      end

      ESCRITA: begin
        rf_we   = 1'b1;
        pc_d    = pc_plus4;
        retire  = 1'b1;
        state_d = BUSCA;
      end

      ERRO: ;

      default: state_d = ERRO;
    endcase
  end

  assign n_instr_d = retire ? n_instr_q + 32'd1 : n_instr_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state and datapath registers, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= BUSCA;
      op_q      <= OP_ADD;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      n_instr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      n_instr_q <= n_instr_d;
    end
  end

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    // NOTE: the register file is cleared on reset because software relies on
    // all registers starting at zero; this keeps it in flops, not a RAM macro.
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we && rd != 5'd0) begin
      regs_q[rd] <= rf_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they hold for the whole
  // request. Reset masks the request so an outstanding access is abandoned.
  // ---------------------------------------------------------------------------
  assign mem.mem_req   = bus_req & ~reset;
  assign mem.mem_we    = bus_we & ~reset;
  assign mem.mem_addr  = bus_addr;
  assign mem.mem_wdata = b_q;

  assign WeM     = mem.mem_req & mem.mem_we;
  assign doutPC  = pc_q;
  assign halted  = (state_q == ERRO);
  assign n_instr = n_instr_q;

endmodule

// File: tb/tb_processador_multiciclo.sv
// Directed bench for processador_multiciclo: an RV64 core (RESET_PC=0x100)
// runs arithmetic, memory-with-wait, branch, illegal-op and reset-abort
// programs; an RV32 core runs the LW/SW and wrap-around regression.
// Memory model: code lives at 0x100-0x1FF and always acks at once; data lives
// below 0x100 and acks after a programmable number of wait cycles.
module tb_processador_multiciclo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset64;
  logic reset32;

  processador_multiciclo_if #(.XLEN(64)) bus64 ();
  processador_multiciclo_if #(.XLEN(32)) bus32 ();

  logic [63:0] pc64;
  logic        wem64;
  logic        halt64;
  logic [31:0] ni64;
  logic [31:0] pc32;
  logic        wem32;
  logic        halt32;
  logic [31:0] ni32;

  processador_multiciclo #(.XLEN(64), .RESET_PC(64'h100)) dut64 (
    .clk     (clk),
    .reset   (reset64),
    .mem     (bus64),
    .doutPC  (pc64),
    .WeM     (wem64),
    .halted  (halt64),
    .n_instr (ni64)
  );

  processador_multiciclo #(.XLEN(32), .RESET_PC(32'h100)) dut32 (
    .clk     (clk),
    .reset   (reset32),
    .mem     (bus32),
    .doutPC  (pc32),
    .WeM     (wem32),
    .halted  (halt32),
    .n_instr (ni32)
  );

  // ---------------------------------------------------------------------------
  // Memory models
  // ---------------------------------------------------------------------------
  logic [31:0] prog64 [64];
  logic [31:0] dmem64 [64];
  logic [31:0] prog32 [64];
  logic [31:0] dmem32 [64];
  int          waits64 = 0;
  int          waits32 = 0;
  bit          force_ack64 = 1'b0;
  int          wcnt64 = 0;
  int          wcnt32 = 0;

  logic [5:0] ia64, ib64, ia32;
  logic       code64, code32;
  assign ia64   = bus64.mem_addr[7:2];
  assign ib64   = ia64 + 6'd1;
  assign ia32   = bus32.mem_addr[7:2];
  assign code64 = bus64.mem_addr[8];
  assign code32 = bus32.mem_addr[8];

  assign bus64.mem_rdata = code64 ? {prog64[ib64], prog64[ia64]} : {dmem64[ib64], dmem64[ia64]};
  assign bus64.mem_ack   = force_ack64 | (bus64.mem_req & (code64 | (wcnt64 >= waits64)));
  assign bus32.mem_rdata = code32 ? prog32[ia32] : dmem32[ia32];
  assign bus32.mem_ack   = bus32.mem_req & (code32 | (wcnt32 >= waits32));

  always @(posedge clk) begin
    if (bus64.mem_req && !bus64.mem_ack) wcnt64 <= wcnt64 + 1;
    else                                 wcnt64 <= 0;
    if (bus64.mem_req && bus64.mem_ack && bus64.mem_we && !code64) begin
      dmem64[ia64] <= bus64.mem_wdata[31:0];
      dmem64[ib64] <= bus64.mem_wdata[63:32];
    end
  end

  always @(posedge clk) begin
    if (bus32.mem_req && !bus32.mem_ack) wcnt32 <= wcnt32 + 1;
    else                                 wcnt32 <= 0;
    if (bus32.mem_req && bus32.mem_ack && bus32.mem_we && !code32) begin
      dmem32[ia32] <= bus32.mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stepping helpers
  // ---------------------------------------------------------------------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          req_cyc;
  int          wem_cyc;
  logic [63:0] wem_addr;
  logic [63:0] wem_data;

  localparam logic [31:0] NEVER = 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog(input bit use32);
    for (int i = 0; i < 64; i++) begin
      if (use32) prog32[i] = 32'h0;
      else       prog64[i] = 32'h0;
    end
  endtask

  task automatic put(input bit use32, input logic [11:0] addr, input logic [31:0] w);
    logic [5:0] idx;
    idx = addr[7:2];
    if (use32) prog32[idx] = w;
    else       prog64[idx] = w;
  endtask

  // Step until n_instr reaches target or the budget runs out, tallying the
  // request and store-strobe activity seen in each cycle.
  task automatic run(input bit use32, input logic [31:0] target, input int budget,
                     output int cycles);
    cycles  = 0;
    req_cyc = 0;
    wem_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (use32 ? bus32.mem_req : bus64.mem_req) req_cyc++;
      if (use32 ? wem32 : wem64) begin
        wem_cyc++;
        wem_addr = use32 ? 64'(bus32.mem_addr)  : bus64.mem_addr;
        wem_data = use32 ? 64'(bus32.mem_wdata) : bus64.mem_wdata;
      end
      @(posedge clk);
      #1;
      cycles++;
      if ((use32 ? ni32 : ni64) == target) break;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset64 = 1'b1;
    reset32 = 1'b1;

    // Program A: arithmetic, x0, store/load with waits, illegal opcode.
    clear_prog(1'b0);
    put(1'b0, 12'h100, enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd5));
    put(1'b0, 12'h104, enc_i(7'b0010011, 3'b000, 5'd2, 5'd0, 12'hFFD));
    put(1'b0, 12'h108, enc_r(7'b0000000, 5'd2, 5'd1, 5'd3));
    put(1'b0, 12'h10C, enc_r(7'b0100000, 5'd1, 5'd2, 5'd4));
    put(1'b0, 12'h110, enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd7));
    put(1'b0, 12'h114, enc_s(12'd16, 5'd3, 5'd0, 3'b011));
    put(1'b0, 12'h118, enc_i(7'b0000011, 3'b011, 5'd5, 5'd0, 12'd16));

    // Reset for two cycles, then first fetch.
    @(posedge clk); #1;
    check("rst_req_c1", 64'(bus64.mem_req), 64'd0);
    check("rst_wem_c1", 64'(wem64), 64'd0);
    @(posedge clk); #1;
    check("rst_req_c2", 64'(bus64.mem_req), 64'd0);
    check("rst_halted", 64'(halt64), 64'd0);
    check("rst_ninstr", 64'(ni64), 64'd0);
    check("rst_pc", pc64, 64'h100);
    reset64 = 1'b0;
    #1;
    check("fetch0_req", 64'(bus64.mem_req), 64'd1);
    check("fetch0_addr", bus64.mem_addr, 64'h100);
    check("fetch0_we", 64'(bus64.mem_we), 64'd0);

    run(1'b0, 32'd5, 40, cyc);
    check("arith_cycles", 64'(cyc), 64'd20);
    check("arith_x1", dut64.regs_q[1], 64'd5);
    check("arith_x2", dut64.regs_q[2], 64'hFFFF_FFFF_FFFF_FFFD);
    check("arith_x3", dut64.regs_q[3], 64'd2);
    check("arith_x4", dut64.regs_q[4], 64'hFFFF_FFFF_FFFF_FFF8);
    check("arith_x0", dut64.regs_q[0], 64'd0);
    check("arith_ninstr", 64'(ni64), 64'd5);
    check("arith_pc", pc64, 64'h114);

    waits64 = 2;
    run(1'b0, 32'd6, 30, cyc);
    check("sd_cycles", 64'(cyc), 64'd6);
    check("sd_wem_cycles", 64'(wem_cyc), 64'd3);
    check("sd_addr", wem_addr, 64'h10);
    check("sd_wdata", wem_data, 64'd2);
    check("sd_mem", 64'(dmem64[4]), 64'd2);

    run(1'b0, 32'd7, 30, cyc);
    check("ld_cycles", 64'(cyc), 64'd7);
    check("ld_x5", dut64.regs_q[5], 64'd2);
    check("ld_pc", pc64, 64'h11C);

    // 0x11C holds 0x00000000: illegal, halts without retiring.
    waits64 = 0;
    run(1'b0, NEVER, 2, cyc);
    check("ill_halted", 64'(halt64), 64'd1);
    check("ill_ninstr", 64'(ni64), 64'd7);
    check("ill_pc", pc64, 64'h11C);
    run(1'b0, NEVER, 6, cyc);
    check("ill_no_req", 64'(req_cyc), 64'd0);

    // Program B: branches, ending in a misaligned taken BEQ.
    reset64 = 1'b1;
    clear_prog(1'b0);
    put(1'b0, 12'h100, enc_b(13'd8, 5'd1, 5'd1));
    put(1'b0, 12'h108, enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd5));
    put(1'b0, 12'h10C, enc_b(13'd8, 5'd2, 5'd1));
    put(1'b0, 12'h110, enc_b(13'd6, 5'd0, 5'd0));
    #1;
    check("rstB_req", 64'(bus64.mem_req), 64'd0);
    @(posedge clk); #1;
    reset64 = 1'b0;
    #1;
    check("recov_halted", 64'(halt64), 64'd0);
    check("recov_req", 64'(bus64.mem_req), 64'd1);
    check("recov_addr", bus64.mem_addr, 64'h100);
    check("recov_ninstr", 64'(ni64), 64'd0);

    run(1'b0, 32'd1, 10, cyc);
    check("beq_t_cycles", 64'(cyc), 64'd3);
    check("beq_t_pc", pc64, 64'h108);
    check("beq_t_fetch", bus64.mem_addr, 64'h108);
    run(1'b0, 32'd2, 10, cyc);
    run(1'b0, 32'd3, 10, cyc);
    check("beq_nt_cycles", 64'(cyc), 64'd3);
    check("beq_nt_pc", pc64, 64'h110);
    check("beq_nt_fetch", bus64.mem_addr, 64'h110);
    run(1'b0, NEVER, 3, cyc);
    check("beq_mis_halted", 64'(halt64), 64'd1);
    run(1'b0, NEVER, 6, cyc);
    check("beq_mis_no_req", 64'(req_cyc), 64'd0);
    check("beq_mis_pc", pc64, 64'h110);
    check("beq_mis_ninstr", 64'(ni64), 64'd3);

    // Program C: reset while a load and then a store wait in MEMORIA.
    reset64 = 1'b1;
    clear_prog(1'b0);
    put(1'b0, 12'h100, enc_i(7'b0000011, 3'b011, 5'd6, 5'd0, 12'd16));
    put(1'b0, 12'h104, enc_s(12'd24, 5'd6, 5'd0, 3'b011));
    waits64 = 10;
    @(posedge clk); #1;
    reset64 = 1'b0;
    run(1'b0, NEVER, 3, cyc);
    check("abrt_ld_req", 64'(bus64.mem_req), 64'd1);
    check("abrt_ld_addr", bus64.mem_addr, 64'h10);
    @(posedge clk); #1;
    reset64     = 1'b1;
    force_ack64 = 1'b1;
    #1;
    check("abrt_ld_rst_req", 64'(bus64.mem_req), 64'd0);
    @(posedge clk); #1;
    reset64     = 1'b0;
    force_ack64 = 1'b0;
    #1;
    check("abrt_ld_x6", dut64.regs_q[6], 64'd0);
    check("abrt_ld_busca", 64'(bus64.mem_req), 64'd1);
    check("abrt_ld_addr0", bus64.mem_addr, 64'h100);
    check("abrt_ld_ninstr", 64'(ni64), 64'd0);

    waits64 = 0;
    run(1'b0, 32'd1, 10, cyc);
    check("ld0_cycles", 64'(cyc), 64'd5);
    check("ld0_x6", dut64.regs_q[6], 64'd2);

    waits64 = 10;
    run(1'b0, NEVER, 3, cyc);
    check("abrt_sd_wem", 64'(wem64), 64'd1);
    check("abrt_sd_addr", bus64.mem_addr, 64'h18);
    check("abrt_sd_wdata", bus64.mem_wdata, 64'd2);
    reset64     = 1'b1;
    force_ack64 = 1'b1;
    #1;
    check("abrt_sd_rst_wem", 64'(wem64), 64'd0);
    @(posedge clk); #1;
    force_ack64 = 1'b0;
    #1;
    check("abrt_sd_ninstr", 64'(ni64), 64'd0);

    // Program D on the RV32 core: LW/SW and wrap-around ADD.
    clear_prog(1'b1);
    put(1'b1, 12'h100, enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'hFFF));
    put(1'b1, 12'h104, enc_i(7'b0010011, 3'b000, 5'd3, 5'd0, 12'd1));
    put(1'b1, 12'h108, enc_r(7'b0000000, 5'd3, 5'd1, 5'd2));
    put(1'b1, 12'h10C, enc_s(12'd32, 5'd1, 5'd0, 3'b010));
    put(1'b1, 12'h110, enc_i(7'b0000011, 3'b010, 5'd4, 5'd0, 12'd32));
    put(1'b1, 12'h114, enc_i(7'b0000011, 3'b011, 5'd5, 5'd0, 12'd32));
    @(posedge clk); #1;
    reset32 = 1'b0;
    #1;
    check("rv32_fetch_addr", 64'(bus32.mem_addr), 64'h100);
    run(1'b1, 32'd3, 30, cyc);
    check("rv32_arith_cycles", 64'(cyc), 64'd12);
    check("rv32_x1", 64'(dut32.regs_q[1]), 64'hFFFF_FFFF);
    check("rv32_wrap_x2", 64'(dut32.regs_q[2]), 64'd0);
    run(1'b1, 32'd4, 10, cyc);
    check("rv32_sw_cycles", 64'(cyc), 64'd4);
    check("rv32_sw_wem", 64'(wem_cyc), 64'd1);
    check("rv32_sw_addr", wem_addr, 64'h20);
    check("rv32_sw_wdata", wem_data, 64'hFFFF_FFFF);
    run(1'b1, 32'd5, 10, cyc);
    check("rv32_lw_cycles", 64'(cyc), 64'd5);
    check("rv32_lw_x4", 64'(dut32.regs_q[4]), 64'hFFFF_FFFF);
    run(1'b1, NEVER, 2, cyc);
    check("rv32_ld_illegal", 64'(halt32), 64'd1);
    check("rv32_ninstr", 64'(ni32), 64'd5);
    check("rv32_pc", 64'(pc32), 64'h114);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
